// File: rtl/nios2_ht18_wang_fu_pcount_master.sv
// nios2_ht18_wang_fu_pcount_master: Avalon-MM master issuing perf-counter STOP/GO/RESET_ALL/SNAPSHOT.
// Define PCOUNT_HI_REREAD_EN to re-read time_hi so a snapshot never tears on a low-word carry.
module nios2_ht18_wang_fu_pcount_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_sec,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_sec,
    output logic [63:0]       rsp_time,
    output logic [31:0]       rsp_events,
    output logic              busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);
    typedef enum logic [2:0] {IDLE, WR, RD_LO, RD_HI, RD_HI2, RD_LO2, RD_EV, RSP} state_t;
`ifdef PCOUNT_HI_REREAD_EN
    localparam state_t RD_FIRST = RD_HI;
    localparam state_t AFTER_HI = RD_LO;
    localparam state_t AFTER_LO = RD_HI2;
`else
    localparam state_t RD_FIRST = RD_LO;
    localparam state_t AFTER_LO = RD_HI;
    localparam state_t AFTER_HI = RD_EV;
`endif
    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic [2:0]  sec_q;
    logic [31:0] lo_q, hi_q;
    logic [4:0]  word;
    logic        done;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx  = state;
        avm_read  = 1'b0;
        avm_write = 1'b0;
        word      = 5'd0;
        case (state)
            IDLE: if (cmd_valid) state_nx = (cmd_op == 2'd3) ? RD_FIRST : WR;
            WR: begin
                avm_write = 1'b1;
                word = (op_q == 2'd2) ? 5'd0 : {sec_q, 1'b0, op_q[0]};
                if (!avm_waitrequest) state_nx = IDLE;
            end
            RD_LO: begin
                avm_read = 1'b1;
                word = {sec_q, 2'd0};
                if (!avm_waitrequest) state_nx = AFTER_LO;
            end
            RD_HI: begin
                avm_read = 1'b1;
                word = {sec_q, 2'd1};
                if (!avm_waitrequest) state_nx = AFTER_HI;
            end
            RD_HI2: begin
                avm_read = 1'b1;
                word = {sec_q, 2'd1};
                if (!avm_waitrequest) state_nx = (avm_readdata == hi_q) ? RD_EV : RD_LO2;
            end
            RD_LO2: begin
                avm_read = 1'b1;
                word = {sec_q, 2'd0};
                if (!avm_waitrequest) state_nx = RD_EV;
            end
            RD_EV: begin
                avm_read = 1'b1;
                word = {sec_q, 2'd2};
                if (!avm_waitrequest) state_nx = RSP;
            end
            RSP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign done          = (avm_read | avm_write) & !avm_waitrequest;
    assign cmd_ready     = state == IDLE;
    assign busy          = state != IDLE;
    assign rsp_valid     = state == RSP;
    assign avm_address   = (avm_read | avm_write) ? ADDR_W'(BASE_ADDR) + ADDR_W'({word, 2'b00}) : '0;
    assign avm_writedata = (avm_write && op_q == 2'd2) ? 32'h1 : 32'h0;
    // A matching second high read leaves hi_q unchanged, so {hi_q, lo_q} is the untorn time either way
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            op_q       <= 2'd0;
            sec_q      <= 3'd0;
            lo_q       <= 32'd0;
            hi_q       <= 32'd0;
            rsp_sec    <= 3'd0;
            rsp_time   <= 64'd0;
            rsp_events <= 32'd0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                op_q  <= cmd_op;
                sec_q <= cmd_sec;
            end
            if (done && (state == RD_LO || state == RD_LO2)) lo_q <= avm_readdata;
            if (done && (state == RD_HI || state == RD_HI2)) hi_q <= avm_readdata;
            if (done && state == RD_EV) begin
                rsp_sec    <= sec_q;
                rsp_time   <= {hi_q, lo_q};
                rsp_events <= avm_readdata;
            end
        end
endmodule
